fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
IF stage directly downstream of the pre-fetch stage; accepts a PC plus exception status and either an already-captured instruction or an in-flight icache request.
- Collects the icache response.
- Holds the instruction while decode stalls.
- Discards stale responses left over from pipeline or BPU flushes.
- Presents a valid instruction bundle to decode under the common valid/allowin handshake.

Parameters:
RESET_PC, 32'hbfc00000, value of the held PC register after reset (debug visibility only)
CANCEL_W, 2, width of the stale-response counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
pfs_to_fs_valid  in  1  pre-fetch has a bundle for IF
pfs_inst_valid  in  1  instruction already captured upstream (pfs_inst valid)
pfs_inst  in  32  captured instruction
pfs_data_cancel  in  1  one outstanding icache response belongs to a cancelled request
pfs_pc  in  32  PC of the bundle
pfs_ex  in  1  fetch exception (AdEL)
pfs_exccode  in  5  exception code
pfs_badvaddr  in  32  faulting address
fs_allowin  out  1  IF can accept this cycle
fs_valid  out  1  IF holds a live bundle
ds_allowin  in  1  decode can accept
flush  in  1  pipeline flush (ex/eret/tlb/cache op)
bpu_flush  in  1  branch-prediction redirect
icache_data_ok  in  1  icache returns data this cycle
icache_rdata  in  32  icache data
fs_to_ds_valid  out  1  bundle to decode valid
ds_pc  out  32  bundle PC
ds_inst  out  32  bundle instruction (0 when ds_ex)
ds_ex  out  1  exception flag
ds_exccode  out  5  exception code
ds_badvaddr  out  32  bad vaddr

Behaviour:
- Reset (async, immediate):
  - fs_valid=0, inst_have=0, cancel_cnt=0.
  - pc_r=RESET_PC; inst_r/ex regs=0.
  - Resulting outputs: fs_allowin=1, fs_to_ds_valid=0.
- Handshake:
  - take_data = fs_valid & !inst_have & !ex_r & cancel_cnt==0 & icache_data_ok.
  - fs_ready_go = ex_r | inst_have | take_data.
  - fs_allowin = !fs_valid | (fs_ready_go & ds_allowin).
  - fs_to_ds_valid = fs_valid & fs_ready_go & !flush & !bpu_flush.
- Accept:
  - Condition: fs_allowin, with no flush and no bpu_flush.
  - fs_valid<=pfs_to_fs_valid; latch pc/ex/exccode/badvaddr.
  - inst_have<=pfs_inst_valid; inst_r<=pfs_inst.
- Data capture:
  - take_data with !ds_allowin: inst_r<=icache_rdata, inst_have<=1.
  - Same-cycle bypass: ds_inst = inst_have ? inst_r : icache_rdata.
  - Zero added latency when data_ok coincides with ds_allowin.
- Flush / bpu_flush (either):
  - Next cycle fs_valid=0, inst_have=0; an accept in the same cycle is dropped.
  - If fs_valid & !inst_have & !ex_r at the flush, that request is still outstanding: cancel_cnt increments.
- Stale-response counter:
  - Increments on accept with pfs_to_fs_valid & pfs_data_cancel.
  - Increments on the flush condition above.
  - Decrements on icache_data_ok when cancel_cnt>0; the decremented response is never captured or forwarded.
  - Simultaneous inc and dec: value unchanged.
  - Two incs in one cycle: +2.
  - Saturates at 2^CANCEL_W-1. Reaching saturation is a design error; the bench asserts it never occurs.
- Exception bundles:
  - Ready immediately; ds_inst=0.
  - Never consume icache_data_ok.
- Hold: outputs stable while fs_to_ds_valid & !ds_allowin.

Decomposition:
- Shared cpu package:
  - fs_to_ds_bus_t (pc, inst, exception_t).
  - exception_t.
  - EXCCODE_ADEL.
  - RESET_PC constant.
- Optional sub-module resp_cancel_ctr: the saturating up/down stale-response counter.

Test Plan:
1. Basic fetch:
   - Stimulus: reset, then bundle pc=0xbfc00000, pfs_inst_valid=0; cycle later icache_data_ok, rdata=0x24010001, ds_allowin=1.
   - Response: fs_to_ds_valid=1 that cycle, ds_inst=0x24010001; fs_allowin=1.
2. Decode stall:
   - Stimulus: data_ok rdata=0x8c220004 with ds_allowin=0 for 3 cycles.
   - Response: inst_have=1, ds_inst held 0x8c220004, fs_allowin=0; releases when ds_allowin=1.
3. Flush while waiting:
   - Stimulus: flush one cycle; next bundle pc=0xbfc00380; stale data_ok rdata=0xdeadbeef; then rdata=0x00000000.
   - Response: 0xdeadbeef never appears on ds_inst; cancel_cnt 1->0; second response forwarded.
4. Upstream cancel:
   - Stimulus: accept with pfs_data_cancel=1, pfs_inst_valid=0.
   - Response: first data_ok dropped, second data_ok forwarded.
5. Exception bundle:
   - Stimulus: pfs_ex=1, exccode=0x04, badvaddr=0xbfc00002.
   - Response: fs_to_ds_valid same cycle as valid, ds_inst=0, no data_ok consumed.
6. Mid-operation reset:
   - Stimulus: assert reset asynchronously between edges with cancel_cnt=1, fs_valid=1.
   - Response: immediately fs_valid=0, fs_allowin=1, cancel_cnt=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU front-end definitions used by the fetch stage.
// Contents:
//   RESET_PC       - PC held by IF after reset
//   EXCCODE_ADEL   - address-error-on-load/fetch exception code
//   exception_t    - exception status carried with a bundle
//   fs_to_ds_bus_t - bundle presented by IF to decode
//   gate_inst      - forces the instruction word to zero for exception bundles
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC     = 32'hbfc00000;
    localparam logic [4:0]  EXCCODE_ADEL = 5'h04;

    typedef struct packed {
        logic        ex;
        logic [4:0]  exccode;
        logic [31:0] badvaddr;
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        exception_t  exc;
    } fs_to_ds_bus_t;

    // A faulting fetch has no meaningful instruction word, so decode sees zero.
    function automatic logic [31:0] gate_inst(input logic ex, input logic [31:0] inst);
        logic [31:0] result;
        if (ex) begin
            result = 32'h0000_0000;
        end else begin
            result = inst;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Handshake and bus signals around the IF stage.
//   pfs_*            : bundle from pre-fetch (PC, captured instruction, exception)
//   fs_allowin       : IF can accept a bundle this cycle
//   fs_valid         : IF holds a live bundle
//   ds_allowin       : decode can accept
//   flush, bpu_flush : pipeline flush / branch-prediction redirect
//   icache_*         : icache response
//   fs_to_ds_valid, ds_* : bundle presented to decode
// slave modport is the fetch stage itself; master modport is its environment.
interface fetch_stage_if;

    logic        pfs_to_fs_valid;
    logic        pfs_inst_valid;
    logic [31:0] pfs_inst;
    logic        pfs_data_cancel;
    logic [31:0] pfs_pc;
    logic        pfs_ex;
    logic [4:0]  pfs_exccode;
    logic [31:0] pfs_badvaddr;
    logic        fs_allowin;
    logic        fs_valid;
    logic        ds_allowin;
    logic        flush;
    logic        bpu_flush;
    logic        icache_data_ok;
    logic [31:0] icache_rdata;
    logic        fs_to_ds_valid;
    logic [31:0] ds_pc;
    logic [31:0] ds_inst;
    logic        ds_ex;
    logic [4:0]  ds_exccode;
    logic [31:0] ds_badvaddr;

    modport master (
        output pfs_to_fs_valid, pfs_inst_valid, pfs_inst, pfs_data_cancel,
               pfs_pc, pfs_ex, pfs_exccode, pfs_badvaddr,
               ds_allowin, flush, bpu_flush, icache_data_ok, icache_rdata,
        input  fs_allowin, fs_valid, fs_to_ds_valid,
               ds_pc, ds_inst, ds_ex, ds_exccode, ds_badvaddr
    );

    modport slave (
        input  pfs_to_fs_valid, pfs_inst_valid, pfs_inst, pfs_data_cancel,
               pfs_pc, pfs_ex, pfs_exccode, pfs_badvaddr,
               ds_allowin, flush, bpu_flush, icache_data_ok, icache_rdata,
        output fs_allowin, fs_valid, fs_to_ds_valid,
               ds_pc, ds_inst, ds_ex, ds_exccode, ds_badvaddr
    );

endinterface

// File: rtl/fetch_stage_resp_cancel_ctr.sv
// Saturating up/down counter of icache responses that belong to cancelled
// requests and must be dropped on arrival.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : number of newly cancelled outstanding requests this cycle (0..2)
//   dec        : an icache response arrives this cycle (consumed only if cnt>0)
//   cnt        : current number of stale responses still to come
module fetch_stage_resp_cancel_ctr #(
    parameter int CANCEL_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          inc,
    input  logic                dec,
    output logic [CANCEL_W-1:0] cnt
);

    localparam int WW = CANCEL_W + 2;
    localparam logic [WW-1:0] MAX_WIDE = {2'b00, {CANCEL_W{1'b1}}};

    logic [CANCEL_W-1:0] cnt_r;
    logic [CANCEL_W-1:0] cnt_next_s;
    logic [WW-1:0]       sum_s;
    logic                dec_eff_s;

    // Next count: add increments, remove one arriving stale response, clamp at max.
    always_comb begin
        dec_eff_s  = dec & (cnt_r != {CANCEL_W{1'b0}});
        sum_s      = {2'b00, cnt_r} + {{CANCEL_W{1'b0}}, inc}
                   - {{(WW-1){1'b0}}, dec_eff_s};
        cnt_next_s = cnt_r;
        if (sum_s > MAX_WIDE) begin
            cnt_next_s = {CANCEL_W{1'b1}};
        end else begin
            cnt_next_s = sum_s[CANCEL_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CANCEL_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: takes a bundle from pre-fetch, collects its icache response
// (or uses the instruction already captured upstream), holds it while decode
// stalls, drops responses of cancelled requests, and hands the bundle to
// decode under the valid/allowin handshake.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   io    : fetch_stage_if.slave (pre-fetch bundle, icache response,
//           flushes, decode handshake and bundle)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC,
    parameter int          CANCEL_W = 2
) (
    input  logic           clk,
    input  logic           reset,
    fetch_stage_if.slave   io
);

    import fetch_stage_pkg::*;

    logic                fs_valid_r;
    logic                inst_have_r;
    logic [31:0]         pc_r;
    logic [31:0]         inst_r;
    exception_t          ex_r;

    logic                flush_any_s;
    logic                cancel_zero_s;
    logic                take_data_s;
    logic                fs_ready_go_s;
    logic                fs_allowin_s;
    logic                accept_s;
    logic                inc_accept_s;
    logic                inc_flush_s;
    logic [1:0]          inc_s;
    logic [CANCEL_W-1:0] cancel_cnt_s;
    fs_to_ds_bus_t       bus_s;

    // Handshake and stale-response bookkeeping.
    always_comb begin
        flush_any_s   = io.flush | io.bpu_flush;
        cancel_zero_s = (cancel_cnt_s == {CANCEL_W{1'b0}});
        // A response is ours only when no stale response is still ahead of it.
        take_data_s   = fs_valid_r & ~inst_have_r & ~ex_r.ex & cancel_zero_s & io.icache_data_ok;
        fs_ready_go_s = ex_r.ex | inst_have_r | take_data_s;
        fs_allowin_s  = ~fs_valid_r | (fs_ready_go_s & io.ds_allowin);
        accept_s      = fs_allowin_s & ~flush_any_s;
        inc_accept_s  = accept_s & io.pfs_to_fs_valid & io.pfs_data_cancel;
        // A flushed bundle still waiting on the icache leaves a response in
        // flight. If that response is arriving in the flush cycle itself it is
        // already gone and must not be counted.
        inc_flush_s   = flush_any_s & fs_valid_r & ~inst_have_r & ~ex_r.ex & ~take_data_s;
        inc_s         = {1'b0, inc_accept_s} + {1'b0, inc_flush_s};
    end

    // Bundle state: accept, capture icache data during a stall, or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid_r  <= 1'b0;
            inst_have_r <= 1'b0;
            pc_r        <= RESET_PC;
            inst_r      <= 32'h0000_0000;
            ex_r        <= '{ex: 1'b0, exccode: 5'h00, badvaddr: 32'h0000_0000};
        end else if (flush_any_s) begin
            fs_valid_r  <= 1'b0;
            inst_have_r <= 1'b0;
        end else if (fs_allowin_s) begin
            fs_valid_r  <= io.pfs_to_fs_valid;
            inst_have_r <= io.pfs_inst_valid;
            inst_r      <= io.pfs_inst;
            pc_r        <= io.pfs_pc;
            ex_r        <= '{ex: io.pfs_ex, exccode: io.pfs_exccode, badvaddr: io.pfs_badvaddr};
        end else if (take_data_s) begin
            // Only reached when decode stalls; otherwise the data bypasses.
            inst_r      <= io.icache_rdata;
            inst_have_r <= 1'b1;
        end
    end

    fetch_stage_resp_cancel_ctr #(
        .CANCEL_W (CANCEL_W)
    ) u_cancel_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_s),
        .dec   (io.icache_data_ok),
        .cnt   (cancel_cnt_s)
    );

    // Bundle to decode, with same-cycle bypass of the icache data.
    always_comb begin
        bus_s.pc   = pc_r;
        bus_s.inst = gate_inst(ex_r.ex, inst_have_r ? inst_r : io.icache_rdata);
        bus_s.exc  = ex_r;
    end

    assign io.fs_allowin     = fs_allowin_s;
    assign io.fs_valid       = fs_valid_r;
    assign io.fs_to_ds_valid = fs_valid_r & fs_ready_go_s & ~flush_any_s;
    assign io.ds_pc          = bus_s.pc;
    assign io.ds_inst        = bus_s.inst;
    assign io.ds_ex          = bus_s.exc.ex;
    assign io.ds_exccode     = bus_s.exc.exccode;
    assign io.ds_badvaddr    = bus_s.exc.badvaddr;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random traffic,
// all compared against a response-queue reference model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if io ();

    fetch_stage #(
        .RESET_PC (32'hbfc00000),
        .CANCEL_W (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one bundle slot plus the in-order list of icache
    // responses still to come (1 = belongs to the live bundle, 0 = stale).
    bit          m_valid;
    bit          m_ex;
    bit          m_have;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [4:0]  m_code;
    logic [31:0] m_bad;
    bit          q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int stale_cnt();
        int n = 0;
        foreach (q[i]) if (!q[i]) n++;
        return n;
    endfunction

    function automatic bit rnd(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_ex = 1'b0; m_have = 1'b0;
        m_pc = 32'hbfc00000; m_inst = 32'h0; m_code = 5'h0; m_bad = 32'h0;
        q.delete();
    endtask

    task automatic idle();
        io.pfs_to_fs_valid = 1'b0; io.pfs_inst_valid = 1'b0; io.pfs_inst = 32'h0;
        io.pfs_data_cancel = 1'b0; io.pfs_pc = 32'h0; io.pfs_ex = 1'b0;
        io.pfs_exccode = 5'h0; io.pfs_badvaddr = 32'h0;
        io.ds_allowin = 1'b1; io.flush = 1'b0; io.bpu_flush = 1'b0;
        io.icache_data_ok = 1'b0; io.icache_rdata = 32'h0;
    endtask

    // One clock: compare outputs with the model, then advance the model at the edge.
    task automatic cycle();
        bit          waiting, data_now, ready, e_tdv, e_allow;
        logic [31:0] e_inst;
        logic [1:0]  c;
        #3;
        waiting  = m_valid && !m_ex && !m_have;
        data_now = waiting && io.icache_data_ok && q.size() > 0 && q[0];
        ready    = m_valid && (m_ex || m_have || data_now);
        e_tdv    = ready && !io.flush && !io.bpu_flush;
        e_allow  = !m_valid || (ready && io.ds_allowin);
        e_inst   = m_ex ? 32'h0 : (m_have ? m_inst : io.icache_rdata);
        c        = dut.u_cancel_ctr.cnt_r;
        chk("fs_valid", io.fs_valid, m_valid);
        chk("fs_allowin", io.fs_allowin, e_allow);
        chk("fs_to_ds_valid", io.fs_to_ds_valid, e_tdv);
        if (e_tdv) begin
            chk("ds_pc", io.ds_pc, m_pc);
            chk("ds_inst", io.ds_inst, e_inst);
            chk("ds_ex", io.ds_ex, m_ex);
            chk("ds_exccode", io.ds_exccode, m_code);
            chk("ds_badvaddr", io.ds_badvaddr, m_bad);
        end
        chk("cancel_cnt", c, 32'(stale_cnt()));
        chk("cancel_sat", (c == 2'b11), 1'b0);
        @(posedge clk);
        if (io.icache_data_ok && q.size() > 0) void'(q.pop_front());
        if (io.flush || io.bpu_flush) begin
            if (waiting && !data_now && q.size() > 0) q[q.size()-1] = 1'b0;
            m_valid = 1'b0;
            m_have  = 1'b0;
        end else if (e_allow) begin
            m_valid = io.pfs_to_fs_valid;
            m_pc    = io.pfs_pc;
            m_ex    = io.pfs_ex;
            m_code  = io.pfs_exccode;
            m_bad   = io.pfs_badvaddr;
            m_have  = io.pfs_inst_valid;
            m_inst  = io.pfs_inst;
            if (io.pfs_to_fs_valid && io.pfs_data_cancel) q.push_back(1'b0);
            if (io.pfs_to_fs_valid && !io.pfs_inst_valid && !io.pfs_ex) q.push_back(1'b1);
        end else if (data_now) begin
            m_have = 1'b1;
            m_inst = io.icache_rdata;
        end
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1'b1;
        #3;
        chk("reset_fs_valid", io.fs_valid, 1'b0);
        chk("reset_fs_allowin", io.fs_allowin, 1'b1);
        chk("reset_tdv", io.fs_to_ds_valid, 1'b0);
        chk("reset_cnt", dut.u_cancel_ctr.cnt_r, 2'd0);
        #19 reset = 1'b0;
        @(posedge clk); #1;
        cycle();

        // Basic fetch with same-cycle bypass
        io.pfs_to_fs_valid = 1'b1; io.pfs_pc = 32'hbfc00000;
        cycle();
        idle(); io.icache_data_ok = 1'b1; io.icache_rdata = 32'h24010001;
        #2;
        chk("t1_tdv", io.fs_to_ds_valid, 1'b1);
        chk("t1_inst", io.ds_inst, 32'h24010001);
        chk("t1_allowin", io.fs_allowin, 1'b1);
        cycle();

        // Decode stall: capture, then hold
        idle(); io.pfs_to_fs_valid = 1'b1; io.pfs_pc = 32'hbfc00004;
        cycle();
        idle(); io.icache_data_ok = 1'b1; io.icache_rdata = 32'h8c220004; io.ds_allowin = 1'b0;
        #2 chk("t2_allowin0", io.fs_allowin, 1'b0);
        cycle();
        for (int i = 0; i < 2; i++) begin
            idle(); io.ds_allowin = 1'b0;
            #2;
            chk("t2_inst_have", dut.inst_have_r, 1'b1);
            chk("t2_inst_hold", io.ds_inst, 32'h8c220004);
            chk("t2_allowin_hold", io.fs_allowin, 1'b0);
            cycle();
        end
        idle();
        #2 chk("t2_release", io.fs_allowin, 1'b1);
        cycle();

        // Flush while waiting for the icache
        idle(); io.pfs_to_fs_valid = 1'b1; io.pfs_pc = 32'hbfc00008;
        cycle();
        idle(); io.flush = 1'b1;
        #2 chk("t3_flush_tdv", io.fs_to_ds_valid, 1'b0);
        cycle();
        idle(); io.pfs_to_fs_valid = 1'b1; io.pfs_pc = 32'hbfc00380;
        cycle();
        idle(); io.icache_data_ok = 1'b1; io.icache_rdata = 32'hdeadbeef;
        #2;
        chk("t3_cnt1", dut.u_cancel_ctr.cnt_r, 2'd1);
        chk("t3_stale_drop", io.fs_to_ds_valid, 1'b0);
        cycle();
        idle(); io.icache_data_ok = 1'b1; io.icache_rdata = 32'h00000000;
        #2;
        chk("t3_cnt0", dut.u_cancel_ctr.cnt_r, 2'd0);
        chk("t3_fwd_tdv", io.fs_to_ds_valid, 1'b1);
        chk("t3_fwd_inst", io.ds_inst, 32'h00000000);
        chk("t3_fwd_pc", io.ds_pc, 32'hbfc00380);
        cycle();

        // Upstream cancel
        idle(); io.pfs_to_fs_valid = 1'b1; io.pfs_data_cancel = 1'b1; io.pfs_pc = 32'hbfc00010;
        cycle();
        idle(); io.icache_data_ok = 1'b1; io.icache_rdata = 32'h11111111;
        #2 chk("t4_drop", io.fs_to_ds_valid, 1'b0);
        cycle();
        idle(); io.icache_data_ok = 1'b1; io.icache_rdata = 32'h22222222;
        #2;
        chk("t4_tdv", io.fs_to_ds_valid, 1'b1);
        chk("t4_inst", io.ds_inst, 32'h22222222);
        cycle();

        // Exception bundle
        idle(); io.pfs_to_fs_valid = 1'b1; io.pfs_ex = 1'b1; io.pfs_exccode = EXCCODE_ADEL;
        io.pfs_badvaddr = 32'hbfc00002; io.pfs_pc = 32'hbfc00002;
        cycle();
        idle(); io.ds_allowin = 1'b0; io.icache_data_ok = 1'b1; io.icache_rdata = 32'h33333333;
        #2;
        chk("t5_tdv", io.fs_to_ds_valid, 1'b1);
        chk("t5_inst", io.ds_inst, 32'h0);
        chk("t5_ex", io.ds_ex, 1'b1);
        chk("t5_code", io.ds_exccode, 5'h04);
        chk("t5_bad", io.ds_badvaddr, 32'hbfc00002);
        cycle();
        idle();
        #2;
        chk("t5_no_consume", dut.inst_have_r, 1'b0);
        chk("t5_inst_still0", io.ds_inst, 32'h0);
        cycle();

        // Asynchronous reset mid-operation
        idle(); io.pfs_to_fs_valid = 1'b1; io.pfs_data_cancel = 1'b1; io.pfs_pc = 32'hbfc00020;
        cycle();
        idle();
        #2 reset = 1'b1;
        #1;
        chk("t6_fs_valid", io.fs_valid, 1'b0);
        chk("t6_allowin", io.fs_allowin, 1'b1);
        chk("t6_cnt", dut.u_cancel_ctr.cnt_r, 2'd0);
        model_reset();
        #3 reset = 1'b0;
        @(posedge clk); #1;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int st;
            st = stale_cnt();
            io.pfs_to_fs_valid = rnd(70);
            io.pfs_inst_valid  = rnd(25);
            io.pfs_inst        = $urandom;
            io.pfs_data_cancel = (st == 0) && rnd(20);
            io.pfs_pc          = $urandom;
            io.pfs_ex          = rnd(10);
            io.pfs_exccode     = 5'($urandom_range(31, 0));
            io.pfs_badvaddr    = $urandom;
            io.icache_data_ok  = (q.size() > 0) && rnd(50);
            io.icache_rdata    = $urandom;
            io.ds_allowin      = rnd(70);
            io.flush           = (st <= 1) && rnd(6);
            io.bpu_flush       = (st <= 1) && rnd(4);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
